tdm_serializer: RTL and testbench

TDM_SERIALIZER -- requirements
Module: tdm_serializer

---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_serializer_if.sv | 25 ++
 rtl/tdm_serializer_frame_edge_detect.sv | 17 +
 rtl/tdm_serializer.sv | 116 +++++++++++
 tb/tb_tdm_serializer.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// Shared constants for the TDM serializer: default geometry and FSM state encodings.
package tdm_pkg;

  localparam int WIDTH_DEF     = 24;
  localparam int CHANNELS_DEF  = 8;
  localparam int SLOT_BITS_DEF = 32;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SHIFT_OWN = 2'd1;
  localparam logic [1:0] ST_PASS      = 2'd2;

endpackage

// File: rtl/tdm_serializer_if.sv
// Sample/frame/serial bundle between a TDM serializer stage and its surroundings.
interface tdm_serializer_if
  import tdm_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int CHANNELS = CHANNELS_DEF
);
  logic                      lr_clk;
  logic                      chain_in;
  logic [CHANNELS*WIDTH-1:0] sample_data;
  logic                      sample_valid;
  logic                      out;
  logic                      frame_start;
  logic                      underrun;

  modport master (
    output lr_clk, chain_in, sample_data, sample_valid,
    input  out, frame_start, underrun
  );

  modport slave (
    input  lr_clk, chain_in, sample_data, sample_valid,
    output out, frame_start, underrun
  );
endinterface

// File: rtl/tdm_serializer_frame_edge_detect.sv
// Rising-edge detector for the frame sync, sampled in the bit-clock domain.
module frame_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic lr_clk,
  output logic frame_edge
);
  logic prev_lr;

  // Reset to 1 so a sync already high at reset release is not taken as a frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_lr <= 1'b1;
    else      prev_lr <= lr_clk;
  end

  assign frame_edge = lr_clk & ~prev_lr;
endmodule

// File: rtl/tdm_serializer.sv
// TDM serializer stage: emits CHANNELS slots of own data per frame, then passes chain data.
// Build option SERIALIZER_DAISY_EN forwards chain_in after the own bits; otherwise PASS outputs 0.
module tdm_serializer
  import tdm_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CHANNELS  = CHANNELS_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF
) (
  input logic             clk,
  input logic             rst,
  tdm_serializer_if.slave bus
);
  localparam int TOTAL = CHANNELS * SLOT_BITS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] DONE = CW'(TOTAL);

  logic                      frame_edge;
  logic [CHANNELS*WIDTH-1:0] hold;
  logic                      fresh;
  logic [TOTAL-1:0]          sr;
  logic [TOTAL-1:0]          load_vec;
  logic [CW-1:0]             cnt;
  logic [1:0]                state;
  logic                      ins_bit;
  logic                      out_q;
  logic                      fs_q;
  logic                      ur_q;

  frame_edge_detect u_edge (
    .clk        (clk),
    .rst        (rst),
    .lr_clk     (bus.lr_clk),
    .frame_edge (frame_edge)
  );

`ifdef SERIALIZER_DAISY_EN
  assign ins_bit = bus.chain_in;
`else
  logic unused_chain;
  assign unused_chain = bus.chain_in;
  assign ins_bit      = 1'b0;
`endif

  // Each channel word sits left-justified in its slot; channel 0 leads the frame.
  always_comb begin
    load_vec = '0;
    if (fresh)
      for (int c = 0; c < CHANNELS; c++)
        load_vec[TOTAL-1-c*SLOT_BITS -: WIDTH] = hold[(CHANNELS-1-c)*WIDTH +: WIDTH];
  end

  // A capture on the edge cycle re-arms fresh for the next frame; the load uses the old hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold  <= '0;
      fresh <= 1'b0;
    end else begin
      if (bus.sample_valid) begin
        hold  <= bus.sample_data;
        fresh <= 1'b1;
      end else if (frame_edge) begin
        fresh <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr    <= '0;
      cnt   <= '0;
      state <= ST_IDLE;
      fs_q  <= 1'b0;
      ur_q  <= 1'b0;
    end else if (frame_edge) begin
      sr    <= load_vec;
      cnt   <= '0;
      state <= ST_SHIFT_OWN;
      fs_q  <= 1'b1;
      ur_q  <= ~fresh;
    end else begin
      fs_q <= 1'b0;
      ur_q <= 1'b0;
      sr   <= {sr[TOTAL-2:0], ins_bit};
      case (state)
        ST_SHIFT_OWN: begin
          if (cnt == LAST) begin
            state <= ST_PASS;
            cnt   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_PASS: cnt <= DONE;
        default: ;
      endcase
    end
  end

  // Own bits leave from the MSB; in PASS the freshly inserted LSB gives a one-clock chain delay.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) out_q <= 1'b0;
    else begin
      case (state)
        ST_SHIFT_OWN: out_q <= sr[TOTAL-1];
        ST_PASS:      out_q <= sr[0];
        default:      out_q <= 1'b0;
      endcase
    end
  end

  assign bus.out         = out_q;
  assign bus.frame_start = fs_q;
  assign bus.underrun    = ur_q;
endmodule

// File: tb/tb_tdm_serializer.sv
// Directed bench for tdm_serializer at WIDTH=4, CHANNELS=2, SLOT_BITS=8.
module tb_tdm_serializer;
  localparam int W = 4;
  localparam int C = 2;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  tdm_serializer_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  tdm_serializer #(.WIDTH(W), .CHANNELS(C), .SLOT_BITS(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  // Past one rising edge, then just after the falling edge where out updates.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Called right after the loading edge; walks all 16 own bits and drops lr_clk mid-frame.
  task automatic frame(input string tag, input logic [15:0] want, input logic want_ur);
    chk({tag, ".fs"}, bus.frame_start, 1'b1);
    chk({tag, ".ur"}, bus.underrun, want_ur);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s.b%0d", tag, i), bus.out, want[15-i]);
      if (i == 3) bus.lr_clk = 1'b0;
      step();
      if (i == 0) begin
        chk({tag, ".fs_pulse"}, bus.frame_start, 1'b0);
        chk({tag, ".ur_pulse"}, bus.underrun, 1'b0);
      end
    end
    chk({tag, ".pass0"}, bus.out, 1'b0);
  endtask

  initial begin
    logic [3:0] pat;
    logic       pass_want;
    pat = 4'b1101;

    rst              = 1'b0;
    bus.lr_clk       = 1'b0;
    bus.chain_in     = 1'b0;
    bus.sample_data  = '0;
    bus.sample_valid = 1'b0;
    step();
    step();
    chk("rst.out", bus.out, 1'b0);
    chk("rst.fs", bus.frame_start, 1'b0);
    chk("rst.ur", bus.underrun, 1'b0);

    rst = 1'b1;
    step();
    step();
    chk("idle.out", bus.out, 1'b0);
    chk("idle.fs", bus.frame_start, 1'b0);

    // Fresh sample then frame edge
    bus.sample_data  = 8'hA5;
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    bus.lr_clk       = 1'b1;
    step();
    frame("s1", 16'b1010_0000_0101_0000, 1'b0);

    // Chain data after own bits
    for (int j = 0; j < 4; j++) begin
      bus.chain_in = pat[3-j];
      step();
`ifdef SERIALIZER_DAISY_EN
      pass_want = pat[3-j];
`else
      pass_want = 1'b0;
`endif
      chk($sformatf("chain.b%0d", j), bus.out, pass_want);
    end
    bus.chain_in = 1'b0;
    step();
    chk("chain.tail", bus.out, 1'b0);

    // No new sample: underrun and zero frame
    bus.lr_clk = 1'b1;
    step();
    frame("s2", 16'h0000, 1'b1);

    // Sample on the edge cycle goes to the next frame
    bus.sample_data  = 8'h96;
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    bus.lr_clk       = 1'b1;
    bus.sample_data  = 8'h3C;
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    frame("s3a", 16'b1001_0000_0110_0000, 1'b0);
    bus.lr_clk = 1'b1;
    step();
    frame("s3b", 16'b0011_0000_1100_0000, 1'b0);

    // Short frame: a second edge at bit 3 reloads (no fresh sample -> zeros)
    bus.sample_data  = 8'hC3;
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    bus.lr_clk       = 1'b1;
    step();
    chk("short.fs", bus.frame_start, 1'b1);
    chk("short.b0", bus.out, 1'b1);
    step();
    chk("short.b1", bus.out, 1'b1);
    bus.lr_clk = 1'b0;
    step();
    chk("short.b2", bus.out, 1'b0);
    bus.lr_clk = 1'b1;
    step();
    chk("short.refs", bus.frame_start, 1'b1);
    chk("short.reur", bus.underrun, 1'b1);
    chk("short.reout", bus.out, 1'b0);

    // Reset mid-frame with lr_clk held high through release
    bus.sample_data  = 8'hFF;
    bus.sample_valid = 1'b1;
    bus.lr_clk       = 1'b0;
    step();
    bus.sample_valid = 1'b0;
    bus.lr_clk       = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rmid.b%0d", i), bus.out, (i < 4) ? 1'b1 : 1'b0);
      step();
    end
    rst = 1'b0;
    #1;
    chk("rmid.out", bus.out, 1'b0);
    step();
    rst = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rrel.out%0d", k), bus.out, 1'b0);
      chk($sformatf("rrel.fs%0d", k), bus.frame_start, 1'b0);
      step();
    end
    bus.lr_clk = 1'b0;
    step();
    bus.lr_clk = 1'b1;
    step();
    chk("rnew.fs", bus.frame_start, 1'b1);
    chk("rnew.ur", bus.underrun, 1'b1);
    chk("rnew.out", bus.out, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
